axi_burst_wr_slave: RTL and testbench
=====================================

# axi_burst_wr_slave

AXI3-style write-only burst responder that terminates the write bursts issued by the team's AXI master (m_aw*/m_w*/m_b* channels) and stores each beat into an internal word memory. It is the far end of the master's write path and the sink the system bench uses to check what the master actually emitted. The block handles one outstanding transaction, supports FIXED and INCR bursts, and returns OKAY/SLVERR/DECERR on the B channel. A side read port exposes the stored words for inspection.

## Interface
- DATA_WIDTH, 32, data bus width; byte lanes = DATA_WIDTH/8
- ADDR_WIDTH, 64, AW address width
- DEPTH, 16, memory words (power of two)
- BASE_ADDR, 64'h0, byte address of memory word 0

- clk  in  1  clock
- areset  in  1  asynchronous active-low reset
- awid_i  in  4  write address ID
- awaddr_i  in  ADDR_WIDTH  burst start byte address
- awlen_i  in  4  beats minus one
- awsize_i  in  3  bytes per beat (log2)
- awburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
- awvalid_i  in  1  / awready_o  out  1  AW handshake
- wid_i  in  4  write data ID
- wdata_i  in  DATA_WIDTH  write data
- wstrb_i  in  DATA_WIDTH/8  byte strobes
- wlast_i  in  1  last beat marker
- wvalid_i  in  1  / wready_o  out  1  W handshake
- bid_o  out  4  response ID (= captured awid)
- bresp_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- bvalid_o  out  1  / bready_i  in  1  B handshake
- mem_raddr_i  in  $clog2(DEPTH)  inspection read address
- mem_rdata_o  out  DATA_WIDTH  inspection read data, registered
- burst_cnt_o  out  16  count of bursts completed with OKAY

## Operation
- FSM states IDLE, DATA, RESP.
- IDLE: awready_o=1, wready_o=0. On awvalid&awready capture id, addr, len, size, burst; beat counter=0; error flags cleared; go DATA.
- DATA: awready_o=0, wready_o=1. Each wvalid&wready is one beat; counter increments.
- Word index of beat n: idx=(awaddr-BASE_ADDR)>>log2(DATA_WIDTH/8); INCR adds n, FIXED adds 0. Arithmetic in ADDR_WIDTH, no wrap: idx>=DEPTH or awaddr<BASE_ADDR is out of range.
- In-range beat with no error condition writes memory; out-of-range beat is accepted and discarded, sets DECERR flag.
- SLVERR conditions (burst data discarded in full): awburst=WRAP or 11; awsize != log2(DATA_WIDTH/8); wid_i != captured awid on any beat; wlast_i value mismatching (counter==awlen) on any beat.
- Burst ends on beat counter==awlen regardless of wlast_i; go RESP.
- RESP: wready_o=0, bvalid_o=1, bid_o=captured id, bresp_o = DECERR if DECERR flag, else SLVERR if SLVERR flag, else OKAY. On bready go IDLE; burst_cnt_o increments (wraps at 2^16) only when bresp was OKAY.
- SLVERR check is resolved at AW capture for burst/size errors, so no beat of such a burst writes memory; wid/wlast errors detected mid-burst stop writes from that beat onward (earlier beats stay written).
- Memory is not cleared by reset.

## Timing
- Reset values: awready_o=0 while areset low, 1 from first clk edge after release (IDLE); wready_o=0, bvalid_o=0, bid_o=0, bresp_o=0, mem_rdata_o=0, burst_cnt_o=0.
- AW accepted at edge T: wready_o=1 from T+1. Earliest beat at T+1.
- Last beat at edge L: bvalid_o=1 from L+1, held with stable bid/bresp until bready; next AW accepted earliest one cycle after B handshake.
- Memory write commits on beat edge; mem_rdata_o reflects mem[mem_raddr_i] one cycle after address; read of a word written on the same edge returns old data.
- Simultaneous awvalid in DATA/RESP: not accepted (awready_o=0). wvalid in IDLE/RESP: ignored.
- areset asserted mid-burst: FSM returns to IDLE immediately, partial burst abandoned, no B response.

## Configuration
- AXI_BURST_WR_SLAVE_WSTRB_EN defined: only byte lanes with wstrb_i=1 are written.
- Undefined: wstrb_i ignored; every accepted in-range beat writes the full word.

## Test plan
- INCR awaddr=BASE+0x8, awlen=3, awsize=2, data 0xA0..0xA3, wlast on beat 3 -> mem[2..5]=0xA0..0xA3, bresp=00, bid=awid, burst_cnt_o=1.
- FIXED awaddr=BASE+0x4, awlen=2, data 0x11,0x22,0x33 -> mem[1]=0x33, bresp=00.
- INCR awaddr=BASE+4*(DEPTH-2), awlen=3 -> mem[DEPTH-2..DEPTH-1] written, bresp=11, burst_cnt_o unchanged.
- awburst=WRAP, awlen=1 -> both beats accepted, memory unchanged, bresp=10; separately wid≠awid on beat 0 -> bresp=10.
- With WSTRB_EN: mem[0]=0xFFFFFFFF, write 0x12345678 wstrb=0101 -> mem[0]=0xFF34FF78; without macro -> 0x12345678.
- areset low during beat 2 of awlen=7 burst with bready held 0 -> no bvalid, awready_o=1 after release, next burst completes with bresp=00.

Source files
------------

// File: rtl/axi_burst_wr_slave.sv
// Write-only AXI3 burst responder: one outstanding burst, FIXED/INCR, stores beats in a word memory.
// Optional AXI_BURST_WR_SLAVE_WSTRB_EN enables per-byte-lane strobe writes.
module axi_burst_wr_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [3:0]               awid_i,
    input  logic [ADDR_WIDTH-1:0]    awaddr_i,
    input  logic [3:0]               awlen_i,
    input  logic [2:0]               awsize_i,
    input  logic [1:0]               awburst_i,
    input  logic                     awvalid_i,
    output logic                     awready_o,
    input  logic [3:0]               wid_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [DATA_WIDTH/8-1:0]  wstrb_i,
    input  logic                     wlast_i,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    output logic [3:0]               bid_o,
    output logic [1:0]               bresp_o,
    output logic                     bvalid_o,
    input  logic                     bready_i,
    input  logic [$clog2(DEPTH)-1:0] mem_raddr_i,
    output logic [DATA_WIDTH-1:0]    mem_rdata_o,
    output logic [15:0]              burst_cnt_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(NB);
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                  state;
    logic [3:0]              id_q, len_q, cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    incr_q, slverr_q, decerr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx;
    logic                    in_range, beat, last, slv_nxt, dec_nxt, we;

    always_comb begin
        idx      = ((addr_q - BASE_ADDR) >> LOG2B) + (incr_q ? ADDR_WIDTH'(cnt_q) : '0);
        // addr below BASE wraps the subtraction, so it must be rejected explicitly
        in_range = (addr_q >= BASE_ADDR) && (idx < ADDR_WIDTH'(DEPTH));
        beat     = (state == DATA) && wvalid_i && wready_o;
        last     = (cnt_q == len_q);
        slv_nxt  = slverr_q || (wid_i != id_q) || (wlast_i != last);
        dec_nxt  = decerr_q || !in_range;
        we       = beat && in_range && !slv_nxt;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state       <= IDLE;
            awready_o   <= 1'b0;
            wready_o    <= 1'b0;
            bvalid_o    <= 1'b0;
            bid_o       <= '0;
            bresp_o     <= '0;
            burst_cnt_o <= '0;
            id_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            incr_q      <= 1'b0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    awready_o <= 1'b1;
                    if (awvalid_i && awready_o) begin
                        id_q      <= awid_i;
                        addr_q    <= awaddr_i;
                        len_q     <= awlen_i;
                        incr_q    <= (awburst_i == 2'b01);
                        cnt_q     <= '0;
                        // burst/size errors known up front: no beat of the burst may write
                        slverr_q  <= awburst_i[1] || (awsize_i != 3'(LOG2B));
                        decerr_q  <= 1'b0;
                        awready_o <= 1'b0;
                        wready_o  <= 1'b1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt_q    <= cnt_q + 4'd1;
                        slverr_q <= slv_nxt;
                        decerr_q <= dec_nxt;
                        if (last) begin
                            wready_o <= 1'b0;
                            bvalid_o <= 1'b1;
                            bid_o    <= id_q;
                            bresp_o  <= dec_nxt ? 2'b11 : (slv_nxt ? 2'b10 : 2'b00);
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bready_i) begin
                        bvalid_o  <= 1'b0;
                        awready_o <= 1'b1;
                        if (bresp_o == 2'b00) burst_cnt_o <= burst_cnt_o + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_BURST_WR_SLAVE_WSTRB_EN
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (we && wstrb_i[b]) mem[idx[IW-1:0]][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb_i;

    always_ff @(posedge clk) begin
        if (we) mem[idx[IW-1:0]] <= wdata_i;
    end
`endif

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) mem_rdata_o <= '0;
        else         mem_rdata_o <= mem[mem_raddr_i];
    end

endmodule

// File: tb/tb_axi_burst_wr_slave.sv
// Directed self-checking bench for axi_burst_wr_slave (DEPTH=16, BASE_ADDR=0x1000).
module tb_axi_burst_wr_slave;
    localparam logic [63:0] BASE = 64'h1000;

    logic        clk = 0, areset = 0;
    logic [3:0]  awid_i = 0, awlen_i = 0, wid_i = 0;
    logic [63:0] awaddr_i = 0;
    logic [2:0]  awsize_i = 0;
    logic [1:0]  awburst_i = 0;
    logic        awvalid_i = 0, awready_o;
    logic [31:0] wdata_i = 0;
    logic [3:0]  wstrb_i = 4'hF;
    logic        wlast_i = 0, wvalid_i = 0, wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o, bready_i = 0;
    logic [3:0]  mem_raddr_i = 0;
    logic [31:0] mem_rdata_o;
    logic [15:0] burst_cnt_o;

    int n_cmp = 0, n_err = 0;

    axi_burst_wr_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(16), .BASE_ADDR(BASE)) dut (
        .clk(clk), .areset(areset),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .mem_raddr_i(mem_raddr_i), .mem_rdata_o(mem_rdata_o), .burst_cnt_o(burst_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic aw(input logic [3:0] id, input logic [63:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        logic ok = 0;
        awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
        awvalid_i = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (awready_o) ok = 1;
            step();
        end
        awvalid_i = 0;
        chk("aw_handshake", ok, 1);
    endtask

    task automatic wb(input logic [3:0] id, input logic [31:0] d, input logic [3:0] strb,
                      input logic lst);
        logic ok = 0;
        wid_i = id; wdata_i = d; wstrb_i = strb; wlast_i = lst; wvalid_i = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (wready_o) ok = 1;
            step();
        end
        wvalid_i = 0; wlast_i = 0;
        chk("w_handshake", ok, 1);
    endtask

    task automatic bresp_chk(input string tag, input logic [3:0] id, input logic [1:0] resp);
        logic ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bvalid_o) ok = 1;
            else step();
        end
        chk({tag, "_bvalid"}, ok, 1);
        chk({tag, "_bid"}, bid_o, id);
        chk({tag, "_bresp"}, bresp_o, resp);
        bready_i = 1;
        step();
        bready_i = 0;
    endtask

    task automatic mem_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        mem_raddr_i = a;
        step();
        chk(tag, mem_rdata_o, exp);
    endtask

    initial begin
        step(); step();
        chk("rst_awready", awready_o, 0);
        chk("rst_wready", wready_o, 0);
        chk("rst_bvalid", bvalid_o, 0);
        chk("rst_bid", bid_o, 0);
        chk("rst_bresp", bresp_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_cnt", burst_cnt_o, 0);
        areset = 1;
        step();
        chk("idle_awready", awready_o, 1);

        // INCR BASE+8 len 3 -> mem[2..5]
        aw(4'd5, BASE + 64'h8, 4'd3, 3'd2, 2'b01);
        chk("data_wready", wready_o, 1);
        chk("data_awready", awready_o, 0);
        for (int n = 0; n < 4; n++) wb(4'd5, 32'hA0 + n, 4'hF, n == 3);
        chk("resp_wready", wready_o, 0);
        step(); step();
        chk("resp_hold_bvalid", bvalid_o, 1);
        bresp_chk("incr", 4'd5, 2'b00);
        chk("incr_cnt", burst_cnt_o, 1);
        mem_chk("incr_m2", 4'd2, 32'hA0);
        mem_chk("incr_m3", 4'd3, 32'hA1);
        mem_chk("incr_m4", 4'd4, 32'hA2);
        mem_chk("incr_m5", 4'd5, 32'hA3);

        // FIXED BASE+4 len 2 -> last beat wins at mem[1]
        aw(4'd3, BASE + 64'h4, 4'd2, 3'd2, 2'b00);
        wb(4'd3, 32'h11, 4'hF, 0);
        wb(4'd3, 32'h22, 4'hF, 0);
        wb(4'd3, 32'h33, 4'hF, 1);
        bresp_chk("fixed", 4'd3, 2'b00);
        chk("fixed_cnt", burst_cnt_o, 2);
        mem_chk("fixed_m1", 4'd1, 32'h33);

        // INCR running off the top -> DECERR, first two beats written
        aw(4'd7, BASE + 64'd56, 4'd3, 3'd2, 2'b01);
        for (int n = 0; n < 4; n++) wb(4'd7, 32'hC0 + n, 4'hF, n == 3);
        bresp_chk("oor", 4'd7, 2'b11);
        chk("oor_cnt", burst_cnt_o, 2);
        mem_chk("oor_m14", 4'd14, 32'hC0);
        mem_chk("oor_m15", 4'd15, 32'hC1);

        // WRAP -> SLVERR, nothing written
        aw(4'd2, BASE + 64'h8, 4'd1, 3'd2, 2'b10);
        wb(4'd2, 32'hDEAD, 4'hF, 0);
        wb(4'd2, 32'hBEEF, 4'hF, 1);
        bresp_chk("wrap", 4'd2, 2'b10);
        mem_chk("wrap_m2", 4'd2, 32'hA0);

        // wid mismatch on beat 0 -> SLVERR, neither beat written
        aw(4'd1, BASE + 64'hC, 4'd1, 3'd2, 2'b01);
        wb(4'd2, 32'h66, 4'hF, 0);
        wb(4'd1, 32'h67, 4'hF, 1);
        bresp_chk("wid", 4'd1, 2'b10);
        mem_chk("wid_m3", 4'd3, 32'hA1);
        mem_chk("wid_m4", 4'd4, 32'hA2);

        // missing wlast on final beat -> SLVERR, beat 0 kept; burst still ends on awlen
        aw(4'd4, BASE + 64'h28, 4'd1, 3'd2, 2'b01);
        wb(4'd4, 32'h100, 4'hF, 0);
        wb(4'd4, 32'h101, 4'hF, 0);
        bresp_chk("wlast", 4'd4, 2'b10);
        mem_chk("wlast_m10", 4'd10, 32'h100);

        // wrong awsize -> SLVERR, no write
        aw(4'd6, BASE + 64'h14, 4'd0, 3'd1, 2'b01);
        wb(4'd6, 32'h55, 4'hF, 1);
        bresp_chk("size", 4'd6, 2'b10);
        mem_chk("size_m5", 4'd5, 32'hA3);
        chk("err_cnt", burst_cnt_o, 2);

        // byte strobes
        aw(4'd0, BASE, 4'd0, 3'd2, 2'b01);
        wb(4'd0, 32'hFFFF_FFFF, 4'hF, 1);
        bresp_chk("strb_a", 4'd0, 2'b00);
        aw(4'd0, BASE, 4'd0, 3'd2, 2'b01);
        wb(4'd0, 32'h1234_5678, 4'b0101, 1);
        bresp_chk("strb_b", 4'd0, 2'b00);
`ifdef AXI_BURST_WR_SLAVE_WSTRB_EN
        mem_chk("strb_m0", 4'd0, 32'hFF34_FF78);
`else
        mem_chk("strb_m0", 4'd0, 32'h1234_5678);
`endif
        chk("strb_cnt", burst_cnt_o, 4);

        // address below BASE -> DECERR
        aw(4'd9, BASE - 64'h4, 4'd0, 3'd2, 2'b01);
        wb(4'd9, 32'h99, 4'hF, 1);
        bresp_chk("below", 4'd9, 2'b11);

        // reset during beat 2 of an 8-beat burst
        aw(4'd8, BASE + 64'h30, 4'd7, 3'd2, 2'b01);
        wb(4'd8, 32'hB0, 4'hF, 0);
        wb(4'd8, 32'hB1, 4'hF, 0);
        wid_i = 4'd8; wdata_i = 32'hB2; wvalid_i = 1;
        areset = 0;
        #1;
        chk("mid_rst_wready", wready_o, 0);
        chk("mid_rst_awready", awready_o, 0);
        wvalid_i = 0;
        step();
        areset = 1;
        step();
        chk("post_rst_awready", awready_o, 1);
        chk("post_rst_bvalid", bvalid_o, 0);
        chk("post_rst_cnt", burst_cnt_o, 0);
        mem_chk("post_rst_m12", 4'd12, 32'hB0);
        aw(4'd8, BASE + 64'h34, 4'd0, 3'd2, 2'b01);
        wb(4'd8, 32'h77, 4'hF, 1);
        bresp_chk("after_rst", 4'd8, 2'b00);
        chk("after_rst_cnt", burst_cnt_o, 1);
        mem_chk("after_rst_m13", 4'd13, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
